// File: rtl/siw_memory_bram_p_pkg.sv
// rtl/siw_memory_bram_p_pkg.sv - shared types and defaults for the SIW block-RAM wrapper
package siw_mem_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_MAX_WR_DLY = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  function automatic int dly_width(input int max_dly);
    return $clog2(max_dly + 1);
  endfunction

endpackage

// File: rtl/siw_memory_bram_p_if.sv
// rtl/siw_memory_bram_p_if.sv - one RAM port bundle; byte_en exists only with SIW_MEM_BYTE_WR_EN
interface siw_memory_bram_p_if
  import siw_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DLY_W  = dly_width(DEF_MAX_WR_DLY)
);

  logic              enable;
  logic              write_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] input_data;
  logic [DLY_W-1:0]  mem_conf;
  logic [DATA_W-1:0] output_data;
`ifdef SIW_MEM_BYTE_WR_EN
  logic [DATA_W/8-1:0] byte_en;
`endif

  modport master (
    output enable, write_en, address, input_data, mem_conf,
`ifdef SIW_MEM_BYTE_WR_EN
    output byte_en,
`endif
    input  output_data
  );

  modport slave (
    input  enable, write_en, address, input_data, mem_conf,
`ifdef SIW_MEM_BYTE_WR_EN
    input  byte_en,
`endif
    output output_data
  );

endinterface

// File: rtl/siw_memory_bram_p_mem.sv
// rtl/siw_memory_bram_p_mem.sv - true dual-port single-clock read-first RAM with byte masks
module siw_tp_mem_sync #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                we_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   din_a,
  input  logic [DATA_W/8-1:0] be_a,
  output logic [DATA_W-1:0]   q_a,
  input  logic                we_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   din_b,
  input  logic [DATA_W/8-1:0] be_b,
  output logic [DATA_W-1:0]   q_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Port A is applied last so it owns any same-address collision.
  always_ff @(posedge clk) begin
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
    if (we_b) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be_b[i]) mem[addr_b][i*8 +: 8] <= din_b[i*8 +: 8];
      end
    end
    if (we_a) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be_a[i]) mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/siw_memory_bram_p.sv
// rtl/siw_memory_bram_p.sv - parametrised two-port BRAM wrapper with write delay lines and clear engine
// Optional byte write masks: SIW_MEM_BYTE_WR_EN
module siw_memory_bram_p
  import siw_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MAX_WR_DLY = DEF_MAX_WR_DLY,
  parameter int DLY_W      = dly_width(MAX_WR_DLY)
) (
  input  logic siw_memory_bram_8_clk_a,
  input  logic siw_memory_bram_8_reset,
  input  logic init,
  input  logic mem_sel,
  output logic busy,
  siw_memory_bram_p_if.slave port_a,
  siw_memory_bram_p_if.slave port_b
);

  localparam int BE_W = DATA_W / 8;

  logic [MAX_WR_DLY:1] dly_a, dly_b;
  logic                wr_a, wr_b;
  clr_state_t          state, state_nx;
  logic [ADDR_W-1:0]   cnt, cnt_nx;

  logic                ram_we_a, ram_we_b;
  logic [ADDR_W-1:0]   ram_addr_a;
  logic [DATA_W-1:0]   ram_din_a;
  logic [BE_W-1:0]     ram_be_a, ram_be_b, be_a_in;
  logic [DATA_W-1:0]   q_a, q_b;

  // conf = 0 bypasses the line; larger values saturate at the last stage.
  function automatic logic tap(input logic we, input logic [MAX_WR_DLY:1] d,
                               input logic [DLY_W-1:0] conf);
    logic r;
    r = we;
    for (int k = 1; k <= MAX_WR_DLY; k++) begin
      if (conf >= DLY_W'(k)) r = d[k];
    end
    return r;
  endfunction

  always_ff @(posedge siw_memory_bram_8_clk_a or posedge siw_memory_bram_8_reset) begin
    if (siw_memory_bram_8_reset) begin
      dly_a <= '0;
      dly_b <= '0;
    end else if (init || busy) begin
      dly_a <= '0;
      dly_b <= '0;
    end else begin
      dly_a[1] <= port_a.write_en;
      dly_b[1] <= port_b.write_en;
      for (int k = 2; k <= MAX_WR_DLY; k++) begin
        dly_a[k] <= dly_a[k-1];
        dly_b[k] <= dly_b[k-1];
      end
    end
  end

  assign wr_a = tap(port_a.write_en, dly_a, port_a.mem_conf);
  assign wr_b = tap(port_b.write_en, dly_b, port_b.mem_conf);

  always_ff @(posedge siw_memory_bram_8_clk_a or posedge siw_memory_bram_8_reset) begin
    if (siw_memory_bram_8_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (init) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == '1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == CLEAR);

`ifdef SIW_MEM_BYTE_WR_EN
  assign be_a_in  = port_a.byte_en;
  assign ram_be_b = port_b.byte_en;
`else
  assign be_a_in  = '1;
  assign ram_be_b = '1;
`endif

  // The clear engine takes over port A completely, including its read address.
  always_comb begin
    ram_we_a   = wr_a & (port_a.enable | mem_sel);
    ram_addr_a = port_a.address;
    ram_din_a  = port_a.input_data;
    ram_be_a   = be_a_in;
    if (busy) begin
      ram_we_a   = 1'b1;
      ram_addr_a = cnt;
      ram_din_a  = '0;
      ram_be_a   = '1;
    end
  end

  assign ram_we_b = wr_b & port_b.enable & ~busy &
                    ~(ram_we_a && (ram_addr_a == port_b.address));

  siw_tp_mem_sync #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (siw_memory_bram_8_clk_a),
    .we_a   (ram_we_a),
    .addr_a (ram_addr_a),
    .din_a  (ram_din_a),
    .be_a   (ram_be_a),
    .q_a    (q_a),
    .we_b   (ram_we_b),
    .addr_b (port_b.address),
    .din_b  (port_b.input_data),
    .be_b   (ram_be_b),
    .q_b    (q_b)
  );

  always_ff @(posedge siw_memory_bram_8_clk_a or posedge siw_memory_bram_8_reset) begin
    if (siw_memory_bram_8_reset) begin
      port_a.output_data <= '0;
      port_b.output_data <= '0;
    end else begin
      port_a.output_data <= q_a;
      port_b.output_data <= q_b;
    end
  end

endmodule

// File: tb/tb_siw_memory_bram_p.sv
// tb/tb_siw_memory_bram_p.sv - scoreboard bench for siw_memory_bram_p
module tb_siw_memory_bram_p;
  import siw_mem_pkg::*;

  localparam int TB_DLY_W = dly_width(DEF_MAX_WR_DLY);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b0;
  logic mem_sel = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  siw_memory_bram_p_if #(.DATA_W(32), .ADDR_W(10), .DLY_W(TB_DLY_W)) pa ();
  siw_memory_bram_p_if #(.DATA_W(32), .ADDR_W(10), .DLY_W(TB_DLY_W)) pb ();

  siw_memory_bram_p dut (
    .siw_memory_bram_8_clk_a (clk),
    .siw_memory_bram_8_reset (rst),
    .init                    (init),
    .mem_sel                 (mem_sel),
    .busy                    (busy),
    .port_a                  (pa),
    .port_b                  (pb)
  );

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) begin
    logic [31:0] got;
    exp_t e;
    cyc = cyc + 1;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      got = e.port ? pb.output_data : pa.output_data;
      n_tests++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input bit port, input logic [9:0] addr, input logic [31:0] exp, input string nm);
    if (port) pb.address = addr;
    else      pa.address = addr;
    sb.push_back('{due: cyc + 2, port: port, exp: exp, name: nm});
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d reads never produced, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wr_a(input logic [9:0] addr, input logic [31:0] data, input logic en, input logic sel);
    pa.enable = en; mem_sel = sel; pa.write_en = 1'b1;
    pa.address = addr; pa.input_data = data;
    tick();
    pa.enable = 1'b0; mem_sel = 1'b0; pa.write_en = 1'b0;
  endtask

  task automatic wr_b(input logic [9:0] addr, input logic [31:0] data);
    pb.enable = 1'b1; pb.write_en = 1'b1;
    pb.address = addr; pb.input_data = data;
    tick();
    pb.enable = 1'b0; pb.write_en = 1'b0;
  endtask

  task automatic test_reset();
    idle(2);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++;
    if (pa.output_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_a: got %h expected 0", pa.output_data); end
    n_tests++;
    if (pb.output_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_b: got %h expected 0", pb.output_data); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    wr_a(10'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    rd(1'b1, 10'd5, 32'hDEADBEEF, "basic_a_to_b");
    wr_a(10'd6, 32'h00000066, 1'b0, 1'b1);
    rd(1'b1, 10'd6, 32'h00000066, "mem_sel_write");
    wr_a(10'd6, 32'h00000077, 1'b0, 1'b0);
    rd(1'b1, 10'd6, 32'h00000066, "unqualified_write_dropped");
    rd(1'b0, 10'd5, 32'hDEADBEEF, "basic_read_a");
    drain();
  endtask

  task automatic test_write_delay();
    wr_a(10'd20, 32'h20202020, 1'b1, 1'b0);
    wr_a(10'd21, 32'h21212121, 1'b1, 1'b0);
    wr_a(10'd7,  32'h00000000, 1'b1, 1'b0);
    idle(4);
    pa.mem_conf = 2'd2;
    pa.enable = 1'b1;
    pa.write_en = 1'b1; pa.address = 10'd20; pa.input_data = 32'hBAD0BAD0;
    tick();
    pa.write_en = 1'b0; pa.address = 10'd21; pa.input_data = 32'hBAD1BAD1;
    tick();
    pa.address = 10'd7; pa.input_data = 32'h00001234;
    tick();
    pa.enable = 1'b0;
    idle(4);
    pa.mem_conf = 2'd0;
    rd(1'b1, 10'd20, 32'h20202020, "delay_no_write_cycle_n");
    rd(1'b1, 10'd21, 32'h21212121, "delay_no_write_cycle_n1");
    rd(1'b1, 10'd7,  32'h00001234, "delay_write_cycle_n2");
    drain();
  endtask

  task automatic test_collision();
    pa.enable = 1'b1; pa.write_en = 1'b1; pa.address = 10'd9; pa.input_data = 32'hAAAA0000;
    pb.enable = 1'b1; pb.write_en = 1'b1; pb.address = 10'd9; pb.input_data = 32'h0000BBBB;
    tick();
    pa.enable = 1'b0; pa.write_en = 1'b0;
    pb.enable = 1'b0; pb.write_en = 1'b0;
    wr_b(10'd10, 32'h0000BBBB);
    rd(1'b0, 10'd9,  32'hAAAA0000, "collision_read_a");
    rd(1'b1, 10'd9,  32'hAAAA0000, "collision_read_b");
    rd(1'b0, 10'd10, 32'h0000BBBB, "port_b_write");
    drain();
  endtask

  task automatic test_clear();
    int n = 0;
    wr_a(10'd0,    32'hFFFFFFFF, 1'b1, 1'b0);
    wr_a(10'd511,  32'hFFFFFFFF, 1'b1, 1'b0);
    wr_a(10'd1023, 32'hFFFFFFFF, 1'b1, 1'b0);
    init = 1'b1;
    tick();
    init = 1'b0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      if (n == 10) init = 1'b1;
      if (n == 11) init = 1'b0;
      if (n == 600) begin
        pb.enable = 1'b1; pb.write_en = 1'b1; pb.address = 10'd300; pb.input_data = 32'h12345678;
      end
      if (n == 601) begin
        pb.enable = 1'b0; pb.write_en = 1'b0;
      end
      tick();
    end
    n_tests++;
    if (n != 1024) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 1024", n); end
    rd(1'b1, 10'd0,    32'h0, "clear_addr0");
    rd(1'b1, 10'd511,  32'h0, "clear_addr511");
    rd(1'b0, 10'd1023, 32'h0, "clear_addr1023");
    rd(1'b1, 10'd300,  32'h0, "clear_blocks_port_b");
    drain();
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    wr_a(10'd1023, 32'hCAFEF00D, 1'b1, 1'b0);
    wr_a(10'd700,  32'h00000700, 1'b1, 1'b0);
    wr_a(10'd50,   32'h00000050, 1'b1, 1'b0);
    init = 1'b1;
    tick();
    init = 1'b0;
    idle(100);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_clear_busy: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_tests++;
    if (pa.output_data !== 32'h0) begin n_fail++; $display("FAIL abort_out_a: got %h expected 0", pa.output_data); end
    n_tests++;
    if (pb.output_data !== 32'h0) begin n_fail++; $display("FAIL abort_out_b: got %h expected 0", pb.output_data); end
    tick();
    rst = 1'b0;
    rd(1'b1, 10'd1023, 32'hCAFEF00D, "abort_keeps_1023");
    rd(1'b1, 10'd700,  32'h00000700, "abort_keeps_700");
    rd(1'b1, 10'd50,   32'h00000000, "abort_cleared_50");
    drain();
    init = 1'b1;
    tick();
    init = 1'b0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    n_tests++;
    if (n != 1024) begin n_fail++; $display("FAIL reclear_busy_cycles: got %0d expected 1024", n); end
    rd(1'b1, 10'd1023, 32'h0, "reclear_1023");
    rd(1'b0, 10'd700,  32'h0, "reclear_700");
    drain();
  endtask

`ifdef SIW_MEM_BYTE_WR_EN
  task automatic test_byte_en();
    pa.byte_en = 4'b1111;
    wr_a(10'd40, 32'h11223344, 1'b1, 1'b0);
    pa.byte_en = 4'b0101;
    wr_a(10'd40, 32'hAABBCCDD, 1'b1, 1'b0);
    pa.byte_en = 4'b1111;
    rd(1'b1, 10'd40, 32'h11BB33DD, "byte_en_merge");
    drain();
  endtask
`endif

  initial begin
    pa.enable = 1'b0; pa.write_en = 1'b0; pa.address = '0; pa.input_data = '0; pa.mem_conf = '0;
    pb.enable = 1'b0; pb.write_en = 1'b0; pb.address = '0; pb.input_data = '0; pb.mem_conf = '0;
`ifdef SIW_MEM_BYTE_WR_EN
    pa.byte_en = '1;
    pb.byte_en = '1;
`endif
    test_reset();
    test_basic();
    test_write_delay();
    test_collision();
    test_clear();
    test_reset_mid_clear();
`ifdef SIW_MEM_BYTE_WR_EN
    test_byte_en();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/siw_memory_bram_p.md
# siw_memory_bram_p

Parametrised two-port block-RAM wrapper for the SIW memory subsystem, the successor to the fixed 1024x32 wrappers. It adds configurable data width and depth, a per-port programmable write-enable delay of 0..MAX_WR_DLY cycles, a registered read output with reset, and a hardware clear engine that zeroes the whole array on `init`. Both ports run in one clock domain and serve the SIW datapath and its configuration bus.

## Interface
- DATA_W, 32: data width in bits; a multiple of 8.
- ADDR_W, 10: address width; DEPTH = 2**ADDR_W words.
- MAX_WR_DLY, 3: maximum write-enable delay in cycles, at least 1.
- DLY_W, $clog2(MAX_WR_DLY+1): width of the mem_conf fields.
- siw_memory_bram_8_clk_a  in  1  clock for both ports.
- siw_memory_bram_8_reset  in  1  asynchronous, active-high reset.
- init  in  1  starts an array clear; also flushes the delay lines.
- mem_sel  in  1  configuration-bus select; qualifies port A writes like enable_a.
- enable_a / enable_b  in  1  port enable.
- write_en_a / write_en_b  in  1  write request, before the delay line.
- address_a / address_b  in  ADDR_W  word address.
- input_data_a / input_data_b  in  DATA_W  write data.
- mem_conf_a / mem_conf_b  in  DLY_W  write-enable delay selection per port.
- byte_en_a / byte_en_b  in  DATA_W/8  byte write mask; present only with SIW_MEM_BYTE_WR_EN.
- output_data_a / output_data_b  out  DATA_W  registered read data.
- busy  out  1  high while the clear engine owns port A.

## Operation
- Delay line, one per port:
  - Shift register d[1..MAX_WR_DLY], with d[1] <= write_en and d[k] <= d[k-1].
  - The effective write wr_x = write_en when mem_conf = 0, otherwise d[mem_conf].
  - mem_conf values above MAX_WR_DLY select d[MAX_WR_DLY].
  - While init or busy is high, every stage loads 0.
- Address and data are not delayed. A write uses the address and data present in the cycle wr_x fires.
- Write qualification:
  - Port A array write = wr_a & (enable_a | mem_sel) & !busy.
  - Port B array write = wr_b & enable_b & !busy.
- Reads happen every cycle on both ports with no enable gating. Read data is read-first: a write to the same address in the same cycle returns the old word.
- Same-address write on both ports in the same cycle: port A wins and port B's write is dropped.
- Clear FSM, states IDLE and CLEAR:
  - IDLE to CLEAR when init = 1. The counter loads 0 and busy goes to 1.
  - In CLEAR, port A writes 0 to address cnt every cycle and cnt increments. Port B writes are blocked.
  - When cnt = DEPTH-1 and that write completes, the FSM returns to IDLE and busy goes to 0.
  - init asserted while in CLEAR is ignored; the clear does not restart.
- Reset values:
  - output_data_a and output_data_b = 0.
  - busy = 0, FSM in IDLE, cnt = 0.
  - All delay-line stages = 0.
  - Array contents are not reset.
- Reset during CLEAR aborts the clear immediately. The array is left partially cleared, and software must assert init again.

## Timing
- Read latency is 2 cycles: address in cycle N, array output in cycle N+1, output_data valid in cycle N+2.
- Write latency is mem_conf cycles from write_en to the array update. The written data is visible on the other port's output_data 2 cycles after the update.
- A clear takes DEPTH cycles; busy stays high for exactly DEPTH cycles, starting the cycle after init is sampled.
- output_data during CLEAR reflects the array contents as they are being cleared; it is not blanked.

## Configuration
- SIW_MEM_BYTE_WR_EN defined:
  - The byte_en ports exist, and byte i is written only when byte_en[i] = 1.
  - byte_en is not delayed; it is sampled with address and data.
  - The clear engine forces all bytes enabled.
- SIW_MEM_BYTE_WR_EN undefined: the byte_en ports are absent and every write is a full word.

## Structure
- Shared package siw_mem_pkg holds:
  - the clear FSM state enum (IDLE, CLEAR);
  - the default DATA_W, ADDR_W and MAX_WR_DLY constants;
  - the $clog2-based DLY_W helper.
- Sub-module siw_tp_mem_sync: a true dual-port, single-clock, read-first RAM with optional byte masks, inferable as BRAM.
- The top level contains the delay lines, the qualification logic, the clear FSM, the port A write mux and the output registers.

## Test plan
All scenarios use DATA_W=32 and ADDR_W=10.
- Basic write/read: mem_conf_a=0, write 0xDEADBEEF to A addr 5, then read B addr 5. output_data_b = 0xDEADBEEF two cycles after the read address.
- Write delay: mem_conf_a=2, write_en_a pulses in cycle N; address 7 and data 0x1234 are applied in cycle N+2. addr 7 = 0x1234, and no write occurs in cycles N and N+1.
- Collision: A writes 0xAAAA0000 and B writes 0x0000BBBB to addr 9 in the same cycle. Readback = 0xAAAA0000.
- Clear: fill addr 0, 511 and 1023 with 0xFFFFFFFF, then pulse init for 1 cycle.
  - busy is high for exactly 1024 cycles.
  - All three addresses read 0 afterwards.
  - A port B write attempted during busy is lost.
- Reset mid-clear: assert reset at cnt=100. busy = 0 and outputs = 0 at once; addr 1023 keeps its old value; init afterwards clears the full array.
- Byte enables (SIW_MEM_BYTE_WR_EN): over 0x11223344, write 0xAABBCCDD with byte_en=4'b0101. Readback = 0x11BB33DD.
